// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared widths, FSM state encoding and beat layout for the register dump reader.
package regfile_dump_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;
endpackage

// File: rtl/regfile_dump_fifo.sv
// regfile_dump_fifo: synchronous FIFO with two ordered push ports and one pop port.
// Ports: clk, rst_n (async active-low); push0/d0 and push1/d1 write in that order in one cycle;
// pop removes head; head is the oldest entry; free is the number of unused slots; empty flags no entries.
module regfile_dump_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push0,
    input  logic [WIDTH-1:0]         d0,
    input  logic                     push1,
    input  logic [WIDTH-1:0]         d1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    assign head  = mem[rp];
    assign empty = count == '0;
    assign free  = CW'(DEPTH) - count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push0) mem[wp] <= d0;
            // push1 lands behind push0 when both fire in the same cycle
            if (push1) mem[wp + AW'(push0)] <= d1;
            wp    <= wp + AW'(push0) + AW'(push1);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through two async read ports and streams {addr,data} beats.
// Ports: clk, rst_n (async active-low); start/first_addr/last_addr request a dump; ra1/ra2 drive the
// register file read addresses and rd1/rd2 return data; out_valid/out_ready/out_addr/out_data carry beats;
// busy spans the dump, done pulses at its end, checksum sums the transferred data.
module regfile_dump_reader #(
    parameter int DATA_W     = regfile_dump_pkg::DATA_W,
    parameter int ADDR_W     = regfile_dump_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    import regfile_dump_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    // one extra bit so a range ending at the top register never wraps back to zero
    logic [ADDR_W:0] ptr, last, nxt1, nxt2;
    logic [CW-1:0] free;
    logic empty, issue, push1, pop;
    assign nxt1      = ptr + (ADDR_W+1)'(1);
    assign nxt2      = ptr + (ADDR_W+1)'(2);
    assign issue     = state == READ && free >= CW'(2);
    assign push1     = issue && nxt1 <= last;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;
    assign ra1       = state == READ ? ptr[ADDR_W-1:0] : '0;
    assign ra2       = state == READ ? nxt1[ADDR_W-1:0] : '0;
    regfile_dump_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push0 (issue),
        .d0    ({ptr[ADDR_W-1:0], rd1}),
        .push1 (push1),
        .d1    ({nxt1[ADDR_W-1:0], rd2}),
        .pop   (pop),
        .head  ({out_addr, out_data}),
        .free  (free),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            last     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
        end else begin
            done <= 1'b0;
            if (pop) checksum <= checksum + out_data;
            case (state)
                IDLE: if (start) begin
                    checksum <= '0;
                    busy     <= 1'b1;
                    ptr      <= {1'b0, first_addr};
                    last     <= {1'b0, last_addr};
                    state    <= first_addr > last_addr ? DONE : READ;
                end
                READ: if (issue) begin
                    ptr <= nxt2;
                    if (nxt2 > last) state <= DRAIN;
                end
                DRAIN: if (empty) state <= DONE;
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
